// File: rtl/lightsaber_settings_regs.sv
// Settings register bank for a blade controller: colour, length and configuration
// are each captured one clock after being presented and cleared asynchronously.
module lightsaber_settings_regs #(
    parameter int COLOR_W = 8,
    parameter int INCH_W  = 2,
    parameter int DEC_W   = 6,
    parameter int CFG_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COLOR_W-1:0] Ri,
    input  logic [COLOR_W-1:0] Gi,
    input  logic [COLOR_W-1:0] Bi,
    input  logic [INCH_W-1:0]  Ini,
    input  logic [DEC_W-1:0]   Deci,
    input  logic [CFG_W-1:0]   configSet,
    output logic [COLOR_W-1:0] Ro,
    output logic [COLOR_W-1:0] Go,
    output logic [COLOR_W-1:0] Bo,
    output logic [INCH_W-1:0]  Ino,
    output logic [DEC_W-1:0]   Deco,
    output logic [CFG_W-1:0]   configOut
);

    // Groups kept in separate processes so each stays an independent register set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Ro <= '0;
            Go <= '0;
            Bo <= '0;
        end else begin
            Ro <= Ri;
            Go <= Gi;
            Bo <= Bi;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Ino  <= '0;
            Deco <= '0;
        end else begin
            Ino  <= Ini;
            Deco <= Deci;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            configOut <= '0;
        end else begin
            configOut <= configSet;
        end
    end

endmodule

// File: tb/tb_lightsaber_settings_regs.sv
// Directed bench for lightsaber_settings_regs: reset behaviour, one-cycle capture,
// hold, boundary values and per-group independence.
module tb_lightsaber_settings_regs;

    logic       clk;
    logic       rst;
    logic [7:0] Ri, Gi, Bi;
    logic [1:0] Ini;
    logic [5:0] Deci;
    logic [1:0] configSet;
    logic [7:0] Ro, Go, Bo;
    logic [1:0] Ino;
    logic [5:0] Deco;
    logic [1:0] configOut;

    int n_assert = 0;
    int n_fail   = 0;

    lightsaber_settings_regs dut (
        .clk       (clk),
        .rst       (rst),
        .Ri        (Ri),
        .Gi        (Gi),
        .Bi        (Bi),
        .Ini       (Ini),
        .Deci      (Deci),
        .configSet (configSet),
        .Ro        (Ro),
        .Go        (Go),
        .Bo        (Bo),
        .Ino       (Ino),
        .Deco      (Deco),
        .configOut (configOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [1:0] in, input logic [5:0] dec, input logic [1:0] cfg);
        Ri = r; Gi = g; Bi = b; Ini = in; Deci = dec; configSet = cfg;
    endtask

    task automatic check(input string tag,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [1:0] in, input logic [5:0] dec, input logic [1:0] cfg);
        n_assert++;
        assert (Ro === r) else begin
            n_fail++; $error("FAIL %s Ro observed=%0d expected=%0d", tag, Ro, r);
        end
        n_assert++;
        assert (Go === g) else begin
            n_fail++; $error("FAIL %s Go observed=%0d expected=%0d", tag, Go, g);
        end
        n_assert++;
        assert (Bo === b) else begin
            n_fail++; $error("FAIL %s Bo observed=%0d expected=%0d", tag, Bo, b);
        end
        n_assert++;
        assert (Ino === in) else begin
            n_fail++; $error("FAIL %s Ino observed=%0d expected=%0d", tag, Ino, in);
        end
        n_assert++;
        assert (Deco === dec) else begin
            n_fail++; $error("FAIL %s Deco observed=%0d expected=%0d", tag, Deco, dec);
        end
        n_assert++;
        assert (configOut === cfg) else begin
            n_fail++; $error("FAIL %s configOut observed=%0d expected=%0d", tag, configOut, cfg);
        end
    endtask

    initial begin
        // Power-up: reset asserted, inputs unknown, no edge yet.
        rst = 1'b0;
        Ri = 'x; Gi = 'x; Bi = 'x; Ini = 'x; Deci = 'x; configSet = 'x;
        #2;
        check("powerup", 8'd0, 8'd0, 8'd0, 2'd0, 6'd0, 2'd0);

        // Edges during reset with known inputs must not load anything.
        drive(8'd17, 8'd34, 8'd51, 2'd1, 6'd9, 2'd1);
        tick();
        tick();
        check("held_in_reset", 8'd0, 8'd0, 8'd0, 2'd0, 6'd0, 2'd0);

        // Release between edges, then first capture.
        #2 rst = 1'b1;
        drive(8'd255, 8'd255, 8'd255, 2'd1, 6'd50, 2'd2);
        #1;
        check("released_no_edge", 8'd0, 8'd0, 8'd0, 2'd0, 6'd0, 2'd0);
        tick();
        check("first_load", 8'd255, 8'd255, 8'd255, 2'd1, 6'd50, 2'd2);

        repeat (190) tick();
        check("hold_190", 8'd255, 8'd255, 8'd255, 2'd1, 6'd50, 2'd2);

        // New values presented mid-cycle: old ones persist until the edge.
        drive(8'd128, 8'd0, 8'd128, 2'd2, 6'd33, 2'd3);
        #2;
        check("before_edge", 8'd255, 8'd255, 8'd255, 2'd1, 6'd50, 2'd2);
        tick();
        check("second_load", 8'd128, 8'd0, 8'd128, 2'd2, 6'd33, 2'd3);

        // All-ones length and configuration fields.
        drive(8'd0, 8'd255, 8'd0, 2'd3, 6'd63, 2'd3);
        tick();
        check("boundary", 8'd0, 8'd255, 8'd0, 2'd3, 6'd63, 2'd3);

        // Configuration codes pass straight through.
        drive(8'd0, 8'd255, 8'd0, 2'd3, 6'd63, 2'd0);
        tick();
        check("cfg_zero", 8'd0, 8'd255, 8'd0, 2'd3, 6'd63, 2'd0);
        drive(8'd0, 8'd255, 8'd0, 2'd3, 6'd63, 2'd1);
        tick();
        check("cfg_one", 8'd0, 8'd255, 8'd0, 2'd3, 6'd63, 2'd1);

        // Mid-cycle reset clears immediately.
        drive(8'd200, 8'd100, 8'd50, 2'd2, 6'd25, 2'd2);
        tick();
        check("pre_reset_load", 8'd200, 8'd100, 8'd50, 2'd2, 6'd25, 2'd2);
        #2 rst = 1'b0;
        #1;
        check("async_clear", 8'd0, 8'd0, 8'd0, 2'd0, 6'd0, 2'd0);
        tick();
        check("reset_edge", 8'd0, 8'd0, 8'd0, 2'd0, 6'd0, 2'd0);
        #2 rst = 1'b1;
        #1;
        check("release_wait", 8'd0, 8'd0, 8'd0, 2'd0, 6'd0, 2'd0);
        tick();
        check("reload", 8'd200, 8'd100, 8'd50, 2'd2, 6'd25, 2'd2);

        // Only green changes.
        Gi = 8'd77;
        tick();
        check("green_only", 8'd200, 8'd77, 8'd50, 2'd2, 6'd25, 2'd2);

        // Only length changes.
        Ini = 2'd0; Deci = 6'd1;
        tick();
        check("length_only", 8'd200, 8'd77, 8'd50, 2'd0, 6'd1, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lightsaber_settings_regs.md
LIGHTSABER_SETTINGS_REGS -- requirements
Module: lightsaber_settings_regs

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter COLOR_W, default 8, SHALL set the width of each colour channel.
REQ-003 Parameter INCH_W, default 2, SHALL set the width of the whole-unit length field.
REQ-004 Parameter DEC_W, default 6, SHALL set the width of the fractional length field.
REQ-005 Parameter CFG_W, default 2, SHALL set the width of the blade-configuration code.
REQ-006 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  SHALL be the asynchronous reset, active-low (0 = reset asserted).
REQ-008 Ri, Gi, Bi  input  COLOR_W each  SHALL be the requested red, green and blue intensities.
REQ-009 Ro, Go, Bo  output  COLOR_W each  SHALL be the registered red, green and blue intensities.
REQ-010 Ini  input  INCH_W  SHALL be the requested whole-unit blade length.
REQ-011 Deci  input  DEC_W  SHALL be the requested fractional (hundredths) blade length.
REQ-012 Ino, Deco  outputs  INCH_W / DEC_W  SHALL be the registered length fields.
REQ-013 configSet  input  CFG_W  SHALL be the requested blade-configuration code.
REQ-014 configOut  output  CFG_W  SHALL be the registered blade-configuration code.

Function
REQ-015 Every output SHALL be driven directly from a dedicated register with no combinational path from any input.
REQ-016 On each rising clk edge with rst high, every register SHALL capture its corresponding input: Ro<=Ri, Go<=Gi, Bo<=Bi, Ino<=Ini, Deco<=Deci, configOut<=configSet.
REQ-017 Latency SHALL be exactly one clock: an input stable at edge N SHALL appear on the output after edge N and hold until the next edge.
REQ-018 The block SHALL have no load enable or handshake; a register whose input is unchanged SHALL hold its value.
REQ-019 Values SHALL be stored bit-exact with no clamping, scaling or wrap-around, including all-ones values (255, 3, 63, 3).
REQ-020 Colour, length and configuration registers SHALL be independent; a change on one input group SHALL NOT affect any other output.
REQ-021 configOut codes 0-3 SHALL be passed through uninterpreted.
REQ-022 Unknown (X) inputs sampled while rst is high MAY propagate to outputs; known outputs are REQUIRED only from reset or from known inputs.

Reset
REQ-023 Asserting rst low SHALL force Ro, Go, Bo, Ino, Deco and configOut to 0 immediately, without waiting for a clock edge.
REQ-024 While rst is low, outputs SHALL remain 0 regardless of clock edges or input values.
REQ-025 After rst rises, the first rising clk edge SHALL load the inputs per REQ-016.
REQ-026 Reset asserted between clock edges SHALL clear state mid-cycle; no captured value SHALL survive the reset.

Verification
REQ-027 Power-up with X inputs, rst=0 -> all outputs read 0 before any clock edge.
REQ-028 rst=1, Ri=Gi=Bi=255, Ini=1, Deci=50, configSet=2, one edge -> Ro=Go=Bo=255, Ino=1, Deco=50, configOut=2; values hold over 190 further cycles with inputs unchanged.
REQ-029 Then Ri=128, Gi=0, Bi=128, Ini=2, Deci=33, configSet=3 -> the old values persist until the next edge; after it the outputs read 128/0/128, 2.33, 3.
REQ-030 Boundary: Ini=3, Deci=63, configSet=3, channels 0/255/0 -> captured exactly, no wrap.
REQ-031 Pull rst low mid-cycle after loaded values -> all outputs 0 within the same cycle; release rst -> the next edge reloads the inputs.
REQ-032 Change only Gi -> only Go changes after the next edge; all other outputs stay constant.
